ram_loader: RTL and testbench

Boot-time loader that sits directly upstream of the 256-byte RAM and fills it from an external byte stream before the CPU runs. It accepts bytes over a valid/ready handshake, places each on the shared bus with the target address on the MAR path, and pulses the RAM's bus-read strobe. It keeps a running 8-bit checksum and reports completion. While busy it owns the bus and MAR path.

---
 rtl/xdn_pkg.sv | 19 +
 rtl/ram_loader.sv | 129 ++++++++++++
 tb/tb_ram_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xdn_pkg.sv
// -----------------------------------------------------------------------------
// xdn_pkg
//   Shared definitions for the boot-time RAM loader and its neighbours on the
//   system bus (RAM, MAR). Holds the default bus/address widths and the
//   2-bit loader state encoding.
// -----------------------------------------------------------------------------
package xdn_pkg;

  localparam int XDN_DATA_WIDTH = 8;  // shared system bus / RAM byte width
  localparam int XDN_ADDR_WIDTH = 8;  // RAM address width, 256 locations

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } loader_state_e;

endpackage : xdn_pkg

// File: rtl/ram_loader.sv
// -----------------------------------------------------------------------------
// ram_loader
//   Fills the 256-byte RAM from an external byte stream before the CPU runs.
//   Each accepted byte is placed on the shared bus for one WRITE cycle with its
//   address on the MAR path and the RAM bus-read strobe high. A running
//   checksum of the loaded bytes is kept and completion is reported with a
//   one-cycle pulse.
//
// Ports
//   i_CLOCK         system clock, rising edge
//   i_RESET_N       asynchronous active-low reset
//   i_START         begin a load (only honoured in IDLE)
//   i_BASE_ADDR     first RAM address written
//   i_LENGTH        byte count, 0..256
//   i_DATA/i_VALID  stream byte and its valid flag
//   o_READY         loader accepts i_DATA this cycle
//   BUS             shared bus, driven only in WRITE, otherwise high-Z
//   o_MAR_DATA      address presented to the RAM
//   o_RAM_READ_BUS  RAM latches BUS at the rising edge ending this cycle
//   o_BUSY          loader owns the bus/MAR path
//   o_DONE          one-cycle completion pulse
//   o_CHECKSUM      sum of loaded bytes, truncated to DATA_WIDTH
// -----------------------------------------------------------------------------
module ram_loader
  import xdn_pkg::*;
#(
  parameter int DATA_WIDTH = XDN_DATA_WIDTH,
  parameter int ADDR_WIDTH = XDN_ADDR_WIDTH
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET_N,
  input  logic                  i_START,
  input  logic [ADDR_WIDTH-1:0] i_BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   i_LENGTH,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_VALID,
  output logic                  o_READY,
  inout  wire  [DATA_WIDTH-1:0] BUS,
  output logic [ADDR_WIDTH-1:0] o_MAR_DATA,
  output logic                  o_RAM_READ_BUS,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic [DATA_WIDTH-1:0] o_CHECKSUM
);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;  // next RAM address to be written
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;    // address shown on the MAR path
  logic [ADDR_WIDTH:0]   rem_q, rem_d;    // bytes still to be written
  logic [DATA_WIDTH-1:0] data_q, data_d;  // byte being written
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mar_d   = mar_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sum_d   = sum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          sum_d = '0;
          if (i_LENGTH != '0) begin
            addr_d  = i_BASE_ADDR;
            rem_d   = i_LENGTH;
            state_d = ST_WAIT_BYTE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT_BYTE: begin
        if (i_VALID) begin
          data_d  = i_DATA;
          sum_d   = sum_q + i_DATA;
          // MAR is loaded here so that it already shows the target address
          // throughout WRITE and keeps the last written address afterwards.
          mar_d   = addr_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;  // wraps 255 -> 0
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == (ADDR_WIDTH + 1)'(1)) ? ST_DONE : ST_WAIT_BYTE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mar_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mar_q   <= mar_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  // Handshake, strobe and bus enable decode from the state register only, so
  // no input reaches these outputs combinationally and reset clears them at once.
  assign o_READY        = (state_q == ST_WAIT_BYTE);
  assign o_RAM_READ_BUS = (state_q == ST_WRITE);
  assign o_BUSY         = (state_q == ST_WAIT_BYTE) || (state_q == ST_WRITE);
  assign o_DONE         = (state_q == ST_DONE);
  assign o_MAR_DATA     = mar_q;
  assign o_CHECKSUM     = sum_q;
  assign BUS            = (state_q == ST_WRITE) ? data_q : {DATA_WIDTH{1'bz}};

endmodule : ram_loader

// File: tb/tb_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_ram_loader
//   Directed bench for ram_loader with a behavioural 256-byte RAM on the bus.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
//   To prove the bus is released, the bench briefly drives 0x00 itself and
//   expects to read back exactly 0x00.
// -----------------------------------------------------------------------------
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_START;
  logic [7:0] i_BASE_ADDR;
  logic [8:0] i_LENGTH;
  logic [7:0] i_DATA;
  logic       i_VALID;
  logic       o_READY;
  wire  [7:0] BUS;
  logic [7:0] o_MAR_DATA;
  logic       o_RAM_READ_BUS;
  logic       o_BUSY;
  logic       o_DONE;
  logic [7:0] o_CHECKSUM;

  logic       tb_drv = 1'b0;
  logic       clr_mem = 1'b0;
  logic [7:0] mem    [256];
  int         wr_cnt [256];
  int         strobes;
  logic [7:0] exp_data [256];
  logic [7:0] exp_sum;

  int vectors = 0;
  int miscompares = 0;

  assign BUS = tb_drv ? 8'h00 : 8'hzz;

  always #5 clk = ~clk;

  ram_loader dut (
    .i_CLOCK       (clk),
    .i_RESET_N     (rst_n),
    .i_START       (i_START),
    .i_BASE_ADDR   (i_BASE_ADDR),
    .i_LENGTH      (i_LENGTH),
    .i_DATA        (i_DATA),
    .i_VALID       (i_VALID),
    .o_READY       (o_READY),
    .BUS           (BUS),
    .o_MAR_DATA    (o_MAR_DATA),
    .o_RAM_READ_BUS(o_RAM_READ_BUS),
    .o_BUSY        (o_BUSY),
    .o_DONE        (o_DONE),
    .o_CHECKSUM    (o_CHECKSUM)
  );

  // Behavioural RAM: latches BUS at the edge ending a strobe cycle.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]    <= 8'h00;
        wr_cnt[i] <= 0;
      end
      strobes <= 0;
    end else if (o_RAM_READ_BUS === 1'b1) begin
      mem[o_MAR_DATA]    <= BUS;
      wr_cnt[o_MAR_DATA] <= wr_cnt[o_MAR_DATA] + 1;
      strobes            <= strobes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_free(input string tag);
    tb_drv = 1'b1;
    #1;
    check(tag, 32'(BUS), 32'h00);
    tb_drv = 1'b0;
  endtask

  task automatic clear_ram();
    clr_mem = 1'b1;
    tick();
    clr_mem = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] len);
    i_START     = 1'b1;
    i_BASE_ADDR = base;
    i_LENGTH    = len;
    tick();
    i_START     = 1'b0;
    exp_sum     = 8'h00;
    check("start_ready", 32'(o_READY), 32'h1);
    check("start_busy", 32'(o_BUSY), 32'h1);
  endtask

  // Entered in WAIT_BYTE; leaves the DUT in WRITE. i_VALID stays high.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
    i_DATA  = d;
    i_VALID = 1'b1;
    check("wait_strobe", 32'(o_RAM_READ_BUS), 32'h0);
    bus_free("wait_bus");
    tick();
    exp_sum = exp_sum + d;
    check("wr_strobe", 32'(o_RAM_READ_BUS), 32'h1);
    check("wr_ready", 32'(o_READY), 32'h0);
    check("wr_mar", 32'(o_MAR_DATA), 32'(a));
    check("wr_bus", 32'(BUS), 32'(d));
  endtask

  // WRITE -> WAIT_BYTE (or a further idle cycle in WAIT_BYTE).
  task automatic wait_cycle();
    tick();
    check("gap_ready", 32'(o_READY), 32'h1);
    check("gap_busy", 32'(o_BUSY), 32'h1);
  endtask

  // From the last WRITE: DONE for one cycle, then IDLE holding results.
  task automatic finish_load(input logic [7:0] last_addr);
    tick();
    check("done_pulse", 32'(o_DONE), 32'h1);
    check("done_busy", 32'(o_BUSY), 32'h0);
    check("done_strobe", 32'(o_RAM_READ_BUS), 32'h0);
    check("done_sum", 32'(o_CHECKSUM), 32'(exp_sum));
    bus_free("done_bus");
    tick();
    check("idle_done", 32'(o_DONE), 32'h0);
    check("idle_ready", 32'(o_READY), 32'h0);
    check("idle_sum", 32'(o_CHECKSUM), 32'(exp_sum));
    check("idle_mar", 32'(o_MAR_DATA), 32'(last_addr));
  endtask

  initial begin
    logic [7:0] b;
    rst_n       = 1'b0;
    i_START     = 1'b0;
    i_BASE_ADDR = 8'h00;
    i_LENGTH    = 9'd0;
    i_DATA      = 8'h00;
    i_VALID     = 1'b0;
    clr_mem     = 1'b1;
    exp_sum     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    clr_mem = 1'b0;
    // Reset state
    check("rst_ready", 32'(o_READY), 32'h0);
    check("rst_strobe", 32'(o_RAM_READ_BUS), 32'h0);
    check("rst_busy", 32'(o_BUSY), 32'h0);
    check("rst_done", 32'(o_DONE), 32'h0);
    check("rst_mar", 32'(o_MAR_DATA), 32'h0);
    check("rst_sum", 32'(o_CHECKSUM), 32'h0);
    bus_free("rst_bus");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(o_READY), 32'h0);

    // Base 0x10, three bytes, i_VALID held high: strobe every 2 cycles.
    clear_ram();
    start_load(8'h10, 9'd3);
    send_byte(8'h11, 8'h10);
    wait_cycle();
    send_byte(8'h22, 8'h11);
    wait_cycle();
    send_byte(8'h33, 8'h12);
    finish_load(8'h12);
    i_VALID = 1'b0;
    check("t1_sum", 32'(o_CHECKSUM), 32'h66);
    check("t1_m10", 32'(mem[8'h10]), 32'h11);
    check("t1_m11", 32'(mem[8'h11]), 32'h22);
    check("t1_m12", 32'(mem[8'h12]), 32'h33);
    check("t1_strobes", 32'(strobes), 32'd3);

    // Base 0xFE, four 0xFF bytes: address wraps, checksum 0xFC.
    clear_ram();
    start_load(8'hFE, 9'd4);
    send_byte(8'hFF, 8'hFE);
    wait_cycle();
    send_byte(8'hFF, 8'hFF);
    wait_cycle();
    send_byte(8'hFF, 8'h00);
    wait_cycle();
    send_byte(8'hFF, 8'h01);
    finish_load(8'h01);
    i_VALID = 1'b0;
    check("t2_sum", 32'(o_CHECKSUM), 32'hFC);
    check("t2_m00", 32'(mem[8'h00]), 32'hFF);
    check("t2_mfe", 32'(mem[8'hFE]), 32'hFF);
    check("t2_strobes", 32'(strobes), 32'd4);

    // Zero length: DONE one cycle after start, no strobe, checksum cleared.
    clear_ram();
    i_START     = 1'b1;
    i_BASE_ADDR = 8'h55;
    i_LENGTH    = 9'd0;
    tick();
    i_START = 1'b0;
    check("z_done", 32'(o_DONE), 32'h1);
    check("z_strobe", 32'(o_RAM_READ_BUS), 32'h0);
    check("z_busy", 32'(o_BUSY), 32'h0);
    check("z_sum", 32'(o_CHECKSUM), 32'h00);
    check("z_mar", 32'(o_MAR_DATA), 32'h01);
    bus_free("z_bus");
    tick();
    check("z_idle", 32'(o_DONE), 32'h0);
    check("z_strobes", 32'(strobes), 32'd0);

    // 256 random bytes from base 0 with random valid gaps.
    clear_ram();
    for (int i = 0; i < 256; i++) exp_data[i] = 8'($urandom_range(0, 255));
    start_load(8'h00, 9'd256);
    for (int i = 0; i < 256; i++) begin
      if (i != 0) wait_cycle();
      repeat ($urandom_range(0, 2)) begin
        i_VALID = 1'b0;
        bus_free("gap_bus");
        wait_cycle();
      end
      send_byte(exp_data[i], 8'(i));
    end
    i_VALID = 1'b0;
    finish_load(8'hFF);
    for (int i = 0; i < 256; i++) begin
      check("full_mem", 32'(mem[i]), 32'(exp_data[i]));
      check("full_once", 32'(wr_cnt[i]), 32'd1);
    end

    // Reset asserted during WRITE of byte 2 of 5.
    clear_ram();
    start_load(8'h40, 9'd5);
    send_byte(8'h31, 8'h40);
    wait_cycle();
    send_byte(8'h32, 8'h41);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", 32'(o_RAM_READ_BUS), 32'h0);
    check("mid_rst_busy", 32'(o_BUSY), 32'h0);
    check("mid_rst_ready", 32'(o_READY), 32'h0);
    check("mid_rst_done", 32'(o_DONE), 32'h0);
    check("mid_rst_mar", 32'(o_MAR_DATA), 32'h0);
    check("mid_rst_sum", 32'(o_CHECKSUM), 32'h0);
    bus_free("mid_rst_bus");
    i_VALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_strobes", 32'(strobes), 32'd1);
    check("mid_rst_m41", 32'(wr_cnt[8'h41]), 32'd0);
    clear_ram();
    start_load(8'h80, 9'd2);
    send_byte(8'h5A, 8'h80);
    wait_cycle();
    send_byte(8'hA5, 8'h81);
    i_VALID = 1'b0;
    finish_load(8'h81);
    check("rl_sum", 32'(o_CHECKSUM), 32'hFF);
    check("rl_m80", 32'(mem[8'h80]), 32'h5A);
    check("rl_m81", 32'(mem[8'h81]), 32'hA5);

    // i_START raised mid-load with another base is ignored.
    clear_ram();
    start_load(8'h20, 9'd3);
    send_byte(8'h01, 8'h20);
    i_START     = 1'b1;
    i_BASE_ADDR = 8'h90;
    i_LENGTH    = 9'd1;
    wait_cycle();
    send_byte(8'h02, 8'h21);
    wait_cycle();
    send_byte(8'h04, 8'h22);
    i_START = 1'b0;
    i_VALID = 1'b0;
    finish_load(8'h22);
    check("ig_sum", 32'(o_CHECKSUM), 32'h07);
    check("ig_strobes", 32'(strobes), 32'd3);
    check("ig_m22", 32'(mem[8'h22]), 32'h04);
    check("ig_m90", 32'(wr_cnt[8'h90]), 32'd0);
    b = o_CHECKSUM;
    repeat (2) tick();
    check("ig_idle", 32'(o_BUSY), 32'h0);
    check("ig_hold", 32'(o_CHECKSUM), 32'(exp_sum));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ram_loader
